ysyx_040066_trap_ctrl: RTL
==========================

Name: ysyx_040066_trap_ctrl

Overview:
- Trap/interrupt sequencer sitting between the commit stage and the machine-mode CSR file.
- Owns the machine timer (mtime/mtimecmp) and decides when a timer interrupt, synchronous exception or mret is taken.
- Drives the CSR file's raise_intr/NO/tval/pc/ret/clear_mip inputs with one-cycle pulses.
- Holds commit and flushes the pipeline while a trap sequence is in progress.

Parameters:
- PRESCALE, 1, core clock cycles per mtime increment (>=1)
- FLUSH_CYCLES, 2, cycles commit stays held after the FIRE cycle (0 allowed)

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-low (rst==0 resets on posedge clk)
- commit_valid  in  1  instruction present at commit
- commit_pc  in  64  PC of commit instruction
- exc_valid  in  1  commit instruction raised a synchronous exception
- exc_cause  in  4  exception code
- exc_tval  in  64  trap value for the exception
- mret_valid  in  1  commit instruction is mret
- mstatus  in  64  current mstatus from CSR file
- mie  in  64  current mie from CSR file
- tmr_wen  in  1  timer register write strobe
- tmr_addr  in  1  0 = mtime, 1 = mtimecmp
- tmr_wdata  in  64  timer write data
- tmr_rdata  out  64  combinational read of the register selected by tmr_addr
- commit_ready  out  1  commit may retire this cycle
- raise_intr  out  1  to CSR file: take trap
- NO  out  64  to CSR file: mcause value
- tval  out  64  to CSR file: mtval value
- pc  out  64  to CSR file: mepc value
- ret  out  1  to CSR file: perform mret
- clear_mip  out  1  to CSR file: clear mip.MTIP
- flush  out  1  kill all younger pipeline stages
- timer_pending  out  1  mtime >= mtimecmp (unsigned)

Behaviour:
Reset:
- state=IDLE, mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, prescale counter=0, drain counter=0.
- raise_intr, ret, clear_mip, flush = 0. NO, tval, pc = 0.
- Reset in any state (including mid-DRAIN) returns to IDLE next edge with these values.

Timer:
- Prescale counter counts 0..PRESCALE-1; mtime increments on the cycle the counter wraps.
- mtime wraps 2^64-1 -> 0 with no flag.
- tmr_wen to mtime: the write wins over the same-cycle increment and clears the prescale counter.
- tmr_wen to mtimecmp: register updated; clear_mip pulses high for exactly the next cycle.
- timer_pending is combinational from the current registers.

Event select (IDLE only, requires commit_valid):
- irq_take = timer_pending & mstatus[3] & mie[7].
- Priority: irq_take > exc_valid > mret_valid.
- irq_take: latch NO={1'b1,63'd7}, tval=0, pc=commit_pc.
- exc_valid: latch NO={60'b0,exc_cause}, tval=exc_tval, pc=commit_pc.
- mret_valid: NO, tval, pc unchanged.
- commit_ready = (state==IDLE) & ~event. The trapping or mret instruction does not retire through the normal path.
- No event, or commit_valid=0: stay IDLE, commit_ready=1. exc_valid/mret_valid without commit_valid are ignored.

FSM:
- IDLE -> FIRE on event, registered.
- FIRE (1 cycle): raise_intr=1 for interrupt/exception, or ret=1 for mret; flush=1.
- FIRE -> DRAIN with drain counter = FLUSH_CYCLES; if FLUSH_CYCLES==0, FIRE -> IDLE.
- DRAIN: flush=0, commit_ready=0; counter decrements; -> IDLE when counter reaches 1.
- All inputs except timer writes are ignored in FIRE/DRAIN.
- A timer interrupt that becomes pending during FIRE/DRAIN is taken at the first IDLE commit where irq_take holds.
- raise_intr and ret are never high in the same cycle. NO/tval/pc remain stable outside FIRE.

Test Plan:
- Reset with rst=0 for 2 cycles mid-DRAIN -> state IDLE, flush=0, raise_intr=0, tmr_rdata(addr1)=all ones, commit_ready=1 when rst=1.
- PRESCALE=1; write mtimecmp=5; mstatus[3]=1, mie[7]=1; commit_valid=1, commit_pc=0x80000010 -> when mtime reaches 5, next cycle raise_intr=1, NO=0x8000000000000007, pc=0x80000010, flush=1; commit_ready=0 for 1+2 cycles.
- exc_valid=1, exc_cause=11, exc_tval=0, commit_pc=0x80000100, same cycle as irq_take -> interrupt wins (NO=0x8000000000000007); with mie[7]=0 -> NO=11, pc=0x80000100.
- mret_valid=1 with commit_valid=1 -> ret=1 for one cycle, raise_intr=0, flush=1, NO unchanged.
- tmr_wen mtimecmp=0x1000 -> clear_mip=1 exactly one cycle; tmr_wen mtime=0xFFFFFFFFFFFFFFFF with PRESCALE=1 -> reads 0 two cycles later.
- FLUSH_CYCLES=0 build: event -> FIRE one cycle -> IDLE; commit_ready low only in the event and FIRE cycles.

Source files
------------

// File: rtl/ysyx_040066_trap_ctrl.sv
// ysyx_040066_trap_ctrl: trap/interrupt sequencer between commit and the M-mode CSR file.
// Owns mtime/mtimecmp and sequences timer interrupts, synchronous exceptions and mret
// as IDLE -> FIRE (one-cycle CSR pulse + flush) -> DRAIN (commit held) -> IDLE.
// Ports:
//   clk, rst (sync, active-low)
//   commit_valid/commit_pc/exc_valid/exc_cause/exc_tval/mret_valid : commit-stage event
//   mstatus/mie    : CSR enables (MIE = mstatus[3], MTIE = mie[7])
//   tmr_wen/tmr_addr/tmr_wdata/tmr_rdata : timer register access (0 = mtime, 1 = mtimecmp)
//   commit_ready   : commit may retire this cycle
//   raise_intr/NO/tval/pc/ret/clear_mip : CSR file controls
//   flush          : kill younger stages
//   timer_pending  : mtime >= mtimecmp
module ysyx_040066_trap_ctrl #(
  parameter int unsigned PRESCALE     = 1,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit_valid,
  input  logic [63:0] commit_pc,
  input  logic        exc_valid,
  input  logic [3:0]  exc_cause,
  input  logic [63:0] exc_tval,
  input  logic        mret_valid,
  input  logic [63:0] mstatus,
  input  logic [63:0] mie,
  input  logic        tmr_wen,
  input  logic        tmr_addr,
  input  logic [63:0] tmr_wdata,
  output logic [63:0] tmr_rdata,
  output logic        commit_ready,
  output logic        raise_intr,
  output logic [63:0] NO,
  output logic [63:0] tval,
  output logic [63:0] pc,
  output logic        ret,
  output logic        clear_mip,
  output logic        flush,
  output logic        timer_pending
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FIRE  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  logic [1:0]  r_state;
  logic [63:0] r_mtime, r_mtimecmp, r_no, r_tval, r_pc;
  logic [31:0] r_ps;
  logic [7:0]  r_drain;
  logic        r_is_ret, r_clear_mip;
  logic        w_idle, w_fire, w_irq, w_event, w_tick, w_unused;
  assign w_unused      = ^{mstatus[63:4], mstatus[2:0], mie[63:8], mie[6:0]};
  assign timer_pending = r_mtime >= r_mtimecmp;
  assign w_idle        = r_state == S_IDLE;
  assign w_fire        = r_state == S_FIRE;
  assign w_irq         = timer_pending & mstatus[3] & mie[7];
  assign w_event       = w_idle & commit_valid & (w_irq | exc_valid | mret_valid);
  assign w_tick        = r_ps == PRESCALE - 1;
  assign tmr_rdata     = tmr_addr ? r_mtimecmp : r_mtime;
  assign commit_ready  = w_idle & ~w_event;
  assign raise_intr    = w_fire & ~r_is_ret;
  assign ret           = w_fire & r_is_ret;
  assign flush         = w_fire;
  assign clear_mip     = r_clear_mip;
  assign NO            = r_no;
  assign tval          = r_tval;
  assign pc            = r_pc;
  // A software write to mtime overrides the same-cycle increment and restarts the prescaler.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mtime     <= '0;
      r_mtimecmp  <= '1;
      r_ps        <= '0;
      r_clear_mip <= 1'b0;
    end else begin
      r_clear_mip <= tmr_wen & tmr_addr;
      if (tmr_wen & ~tmr_addr) begin
        r_mtime <= tmr_wdata;
        r_ps    <= '0;
      end else begin
        r_ps <= w_tick ? '0 : r_ps + 32'd1;
        if (w_tick) r_mtime <= r_mtime + 64'd1;
      end
      if (tmr_wen & tmr_addr) r_mtimecmp <= tmr_wdata;
    end
  end
  // mret leaves NO/tval/pc untouched so the CSR file sees stable values outside traps.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_drain  <= '0;
      r_is_ret <= 1'b0;
      r_no     <= '0;
      r_tval   <= '0;
      r_pc     <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_event) begin
          r_state  <= S_FIRE;
          r_is_ret <= ~w_irq & ~exc_valid;
          if (w_irq | exc_valid) begin
            r_no   <= w_irq ? {1'b1, 63'd7} : {60'd0, exc_cause};
            r_tval <= w_irq ? 64'd0 : exc_tval;
            r_pc   <= commit_pc;
          end
        end
        S_FIRE: begin
          r_state <= (FLUSH_CYCLES == 0) ? S_IDLE : S_DRAIN;
          r_drain <= FLUSH_CYCLES[7:0];
        end
        S_DRAIN: begin
          r_drain <= r_drain - 8'd1;
          if (r_drain == 8'd1) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
